// File: rtl/csr_int_ctrl_pkg.sv
// Shared CSR definitions for the interrupt/timer controller: addresses, field positions
// and FSM encodings.
package csr_int_ctrl_pkg;

   localparam logic [13:0] CsrEstat = 14'h005;
   localparam logic [13:0] CsrTcfg  = 14'h041;
   localparam logic [13:0] CsrTval  = 14'h042;
   localparam logic [13:0] CsrTiclr = 14'h044;

   localparam int unsigned TcfgEn       = 0;
   localparam int unsigned TcfgPeriodic = 1;
   localparam int unsigned TcfgInitLsb  = 2;
   localparam int unsigned TcfgInitMsb  = 31;

   localparam int unsigned IsSwiLsb = 0;
   localparam int unsigned IsSwiMsb = 1;
   localparam int unsigned IsHwiLsb = 2;
   localparam int unsigned IsHwiMsb = 9;
   localparam int unsigned IsTi     = 11;
   localparam int unsigned IsIpi    = 12;
   localparam int unsigned IsWidth  = 13;

   typedef enum logic [1:0] {
      IntIdle = 2'd0,
      IntPend = 2'd1,
      IntHold = 2'd2
   } int_state_e;

   // Timer reload value: INITVAL is stored word-aligned, so it counts in units of 4.
   function automatic logic [31:0] tcfg_reload(input logic [31:0] tcfg);
      return {tcfg[TcfgInitMsb:TcfgInitLsb], 2'b00};
   endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-stage flip-flop synchroniser for a vector of asynchronous level signals.
module int_sync #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] chain_q [STAGES];
   logic [WIDTH-1:0] chain_d [STAGES];

   always_comb begin
      chain_d[0] = async_i;
      for (int i = 1; i < STAGES; i++) begin
         chain_d[i] = chain_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= chain_d[i];
         end
      end
   end

   assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/csr_int_ctrl.sv
// Interrupt and timer controller: owns ESTAT.IS, TCFG/TVAL/TICLR and chooses the single
// commit cycle at which an interrupt is injected into the CSR exception path.
module csr_int_ctrl
   import csr_int_ctrl_pkg::*;
#(
   parameter int unsigned HWI_NUM     = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMER_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic [HWI_NUM-1:0]   hw_int,
   input  logic                 ipi,
   input  logic                 csr_we,
   input  logic [13:0]          csr_addr,
   input  logic [31:0]          csr_wdata,
   input  logic                 crmd_ie,
   input  logic [IsWidth-1:0]   ecfg_lie,
   input  logic                 commit_valid,
   input  logic                 except_en,
   output logic [IsWidth-1:0]   estat_is,
   output logic [31:0]          tcfg_rdata,
   output logic [TIMER_W-1:0]   tval_rdata,
   output logic                 int_req,
   output logic                 int_pending
);

   logic [HWI_NUM-1:0]           hw_sync;
   logic [IsHwiMsb-IsHwiLsb:0]   hwi_lvl;

   logic [1:0]         swi_q, swi_d;
   logic               ti_q, ti_d;
   logic               ipi_q;
   logic [31:0]        tcfg_q, tcfg_d;
   logic [TIMER_W-1:0] tval_q, tval_d;
   int_state_e         state_q, state_d;
   logic               int_req_q, int_req_d;

   logic               wr_ok, estat_wr, tcfg_wr, ticlr_wr, expire;

   int_sync #(
      .WIDTH  (HWI_NUM),
      .STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (hw_int),
      .sync_o  (hw_sync)
   );

   // Unused hardware lines above HWI_NUM read as zero.
   always_comb begin
      hwi_lvl = '0;
      hwi_lvl[HWI_NUM-1:0] = hw_sync;
   end

   assign wr_ok    = csr_we & ~stall;
   assign estat_wr = wr_ok & (csr_addr == CsrEstat);
   assign tcfg_wr  = wr_ok & (csr_addr == CsrTcfg);
   assign ticlr_wr = wr_ok & (csr_addr == CsrTiclr);

   assign swi_d = estat_wr ? csr_wdata[IsSwiMsb:IsSwiLsb] : swi_q;

   // A TCFG write overrides a coincident expiry: reload and no IS[11] set.
   always_comb begin
      tcfg_d = tcfg_q;
      tval_d = tval_q;
      expire = 1'b0;
      if (tcfg_wr) begin
         tcfg_d = csr_wdata;
         tval_d = TIMER_W'(tcfg_reload(csr_wdata));
      end else if (tcfg_q[TcfgEn]) begin
         if (tval_q != '0) begin
            tval_d = tval_q - TIMER_W'(1);
         end else begin
            expire = 1'b1;
            if (tcfg_q[TcfgPeriodic]) begin
               tval_d = TIMER_W'(tcfg_reload(tcfg_q));
            end else begin
               tcfg_d[TcfgEn] = 1'b0;
               tval_d = '1;
            end
         end
      end
   end

   // Expiry is evaluated after the clear so that a coincident set wins.
   always_comb begin
      ti_d = ti_q;
      if (ticlr_wr && csr_wdata[0]) begin
         ti_d = 1'b0;
      end
      if (expire) begin
         ti_d = 1'b1;
      end
   end

   assign estat_is    = {ipi_q, ti_q, 1'b0, hwi_lvl, swi_q};
   assign int_pending = (|(estat_is & ecfg_lie)) & crmd_ie;

   always_comb begin
      state_d   = state_q;
      int_req_d = 1'b0;
      unique case (state_q)
         IntIdle: begin
            if (int_pending) begin
               state_d = IntPend;
            end
         end
         IntPend: begin
            if (!int_pending) begin
               state_d = IntIdle;
            end else if (commit_valid && !stall && !except_en) begin
               state_d   = IntHold;
               int_req_d = 1'b1;
            end
         end
         IntHold: begin
            // Leave once the CSR has taken the exception (IE cleared) or the source went away.
            if (!crmd_ie || !int_pending) begin
               state_d = IntIdle;
            end
         end
         default: state_d = IntIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         swi_q     <= '0;
         ti_q      <= 1'b0;
         ipi_q     <= 1'b0;
         tcfg_q    <= '0;
         tval_q    <= '1;
         state_q   <= IntIdle;
         int_req_q <= 1'b0;
      end else begin
         swi_q     <= swi_d;
         ti_q      <= ti_d;
         ipi_q     <= ipi;
         tcfg_q    <= tcfg_d;
         tval_q    <= tval_d;
         state_q   <= state_d;
         int_req_q <= int_req_d;
      end
   end

   assign tcfg_rdata = tcfg_q;
   assign tval_rdata = tval_q;
   assign int_req    = int_req_q;

endmodule

// File: tb/tb_csr_int_ctrl.sv
// Directed self-checking bench for csr_int_ctrl: timer, TICLR, sync, and injection sequencing.
module tb_csr_int_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [7:0]  hw_int;
   logic        ipi;
   logic        csr_we;
   logic [13:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        crmd_ie;
   logic [12:0] ecfg_lie;
   logic        commit_valid;
   logic        except_en;
   logic [12:0] estat_is;
   logic [31:0] tcfg_rdata;
   logic [31:0] tval_rdata;
   logic        int_req;
   logic        int_pending;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned pulses;

   csr_int_ctrl u_dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .hw_int       (hw_int),
      .ipi          (ipi),
      .csr_we       (csr_we),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .crmd_ie      (crmd_ie),
      .ecfg_lie     (ecfg_lie),
      .commit_valid (commit_valid),
      .except_en    (except_en),
      .estat_is     (estat_is),
      .tcfg_rdata   (tcfg_rdata),
      .tval_rdata   (tval_rdata),
      .int_req      (int_req),
      .int_pending  (int_pending)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [13:0] addr, input logic [31:0] data);
      csr_we    = 1'b1;
      csr_addr  = addr;
      csr_wdata = data;
      tick();
      csr_we    = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; hw_int = '0; ipi = 1'b0;
      csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
      crmd_ie = 1'b0; ecfg_lie = '0; commit_valid = 1'b0; except_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset while the timer is counting
      csr_write(14'h041, 32'h0000_000B);
      check_eq("pre_reset_tval", tval_rdata, 32'd8);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_eq("rst_tval", tval_rdata, 32'hFFFF_FFFF);
      check_eq("rst_tcfg", tcfg_rdata, 32'h0);
      check_eq("rst_is", {19'h0, estat_is}, 32'h0);
      check_eq("rst_int_req", {31'h0, int_req}, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      check_eq("post_rst_tval_idle", tval_rdata, 32'hFFFF_FFFF);

      // Periodic timer, INITVAL=2
      csr_write(14'h041, 32'h0000_000B);
      check_eq("per_load_tval", tval_rdata, 32'd8);
      check_eq("per_tcfg", tcfg_rdata, 32'h0000_000B);
      for (int v = 7; v >= 0; v--) begin
         tick();
         check_eq("per_count", tval_rdata, 32'(v));
      end
      check_eq("per_ti_before", {31'h0, estat_is[11]}, 32'h0);
      tick();
      check_eq("per_ti_set", {31'h0, estat_is[11]}, 32'h1);
      check_eq("per_reload", tval_rdata, 32'd8);
      csr_write(14'h044, 32'h1);
      check_eq("ticlr_clear", {31'h0, estat_is[11]}, 32'h0);
      check_eq("ticlr_tval", tval_rdata, 32'd7);
      repeat (7) tick();
      check_eq("per_at_zero", tval_rdata, 32'd0);
      csr_write(14'h044, 32'h1);
      check_eq("ticlr_vs_expiry", {31'h0, estat_is[11]}, 32'h1);
      check_eq("ticlr_vs_expiry_tval", tval_rdata, 32'd8);
      csr_write(14'h044, 32'h1);
      check_eq("ticlr_clear2", {31'h0, estat_is[11]}, 32'h0);

      // One-shot timer, INITVAL=1
      csr_write(14'h041, 32'h0000_0005);
      check_eq("os_load", tval_rdata, 32'd4);
      repeat (4) tick();
      check_eq("os_zero", tval_rdata, 32'd0);
      tick();
      check_eq("os_ti_set", {31'h0, estat_is[11]}, 32'h1);
      check_eq("os_tval_ones", tval_rdata, 32'hFFFF_FFFF);
      check_eq("os_en_cleared", tcfg_rdata, 32'h0000_0004);
      csr_write(14'h044, 32'h1);
      repeat (20) tick();
      check_eq("os_no_second", {31'h0, estat_is[11]}, 32'h0);
      check_eq("os_tval_hold", tval_rdata, 32'hFFFF_FFFF);

      // Hardware interrupt through the synchroniser and injection
      ecfg_lie = 13'h020;
      crmd_ie  = 1'b1;
      hw_int   = 8'h08;
      tick();
      check_eq("sync_stage1", {31'h0, estat_is[5]}, 32'h0);
      tick();
      check_eq("sync_stage2", {31'h0, estat_is[5]}, 32'h1);
      check_eq("pending", {31'h0, int_pending}, 32'h1);
      commit_valid = 1'b1;
      tick();
      check_eq("inj_pend", {31'h0, int_req}, 32'h0);
      tick();
      check_eq("inj_pulse", {31'h0, int_req}, 32'h1);
      tick();
      check_eq("inj_hold1", {31'h0, int_req}, 32'h0);
      tick();
      check_eq("inj_hold2", {31'h0, int_req}, 32'h0);
      crmd_ie = 1'b0;
      #1;
      check_eq("pending_masked", {31'h0, int_pending}, 32'h0);
      tick();
      tick();

      // Stall and except_en block injection
      stall   = 1'b1;
      crmd_ie = 1'b1;
      pulses  = 0;
      repeat (5) begin
         tick();
         pulses += int_req;
      end
      check_eq("stall_block", pulses, 32'h0);
      stall     = 1'b0;
      except_en = 1'b1;
      tick();
      check_eq("except_block", {31'h0, int_req}, 32'h0);
      except_en = 1'b0;
      tick();
      check_eq("first_qualify", {31'h0, int_req}, 32'h1);
      tick();
      check_eq("single_pulse", {31'h0, int_req}, 32'h0);

      crmd_ie = 1'b0; hw_int = '0; commit_valid = 1'b0;
      repeat (3) tick();
      check_eq("is_cleared", {19'h0, estat_is}, 32'h0);

      // Pending drops in PEND: no injection
      crmd_ie  = 1'b1;
      ecfg_lie = 13'h1000;
      ipi      = 1'b1;
      tick();
      check_eq("ipi_is", {19'h0, estat_is}, 32'h0000_1000);
      tick();
      ecfg_lie     = '0;
      commit_valid = 1'b1;
      pulses       = 0;
      repeat (3) begin
         tick();
         pulses += int_req;
      end
      check_eq("pend_drop", pulses, 32'h0);
      commit_valid = 1'b0;
      crmd_ie      = 1'b0;

      // ESTAT software bits, stall-gated writes, read-only TVAL
      csr_write(14'h005, 32'h3);
      check_eq("swi_write", {19'h0, estat_is}, 32'h0000_1003);
      stall = 1'b1;
      csr_write(14'h005, 32'h0);
      check_eq("swi_stalled", {30'h0, estat_is[1:0]}, 32'h3);
      csr_write(14'h041, 32'h0000_000B);
      check_eq("tcfg_stalled", tcfg_rdata, 32'h0000_0004);
      stall = 1'b0;
      csr_write(14'h042, 32'h0);
      check_eq("tval_ro", tval_rdata, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
